// File: rtl/tone_pkg.sv
// Shared note indices, mid-octave frequency table, half-period helper and FSM states.
// Pure declarations; no timing or flow control of its own.
package tone_pkg;

  localparam int TONE_HP_W = 20;

  localparam logic [2:0] REST = 3'd0;
  localparam logic [2:0] DO   = 3'd1;
  localparam logic [2:0] RE   = 3'd2;
  localparam logic [2:0] MI   = 3'd3;
  localparam logic [2:0] FA   = 3'd4;
  localparam logic [2:0] SOL  = 3'd5;
  localparam logic [2:0] LA   = 3'd6;
  localparam logic [2:0] SI   = 3'd7;

  localparam int unsigned F_MID [7] = '{262, 294, 330, 349, 392, 440, 494};

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  // Octave 3 falls through to the mid value.
  function automatic logic [TONE_HP_W-1:0] hp_of(input logic [2:0] note,
                                                 input logic [1:0] octave,
                                                 input int unsigned clk_hz);
    int unsigned hp;
    hp = 0;
    if (note != REST) hp = clk_hz / (2 * F_MID[note - 3'd1]);
    case (octave)
      2'd0:    hp = hp << 1;
      2'd2:    hp = hp >> 1;
      default: hp = hp;
    endcase
    return hp[TONE_HP_W-1:0];
  endfunction

endpackage

// File: rtl/tone_generator_square_divider.sv
// Square-wave divider: toggles out every half_period clocks while run is high.
// Latency: first toggle half_period cycles after run rises; clearing run zeroes out on the next edge.
module square_divider #(
  parameter int HP_W = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [HP_W-1:0] half_period,
  output logic            out
);

  localparam logic [HP_W-1:0] ONE = HP_W'(1);

  logic [HP_W-1:0] hp_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_cnt <= '0;
      out    <= 1'b0;
    end else if (!run) begin
      hp_cnt <= '0;
      out    <= 1'b0;
    end else if (hp_cnt == half_period - ONE) begin
      hp_cnt <= '0;
      out    <= ~out;
    end else begin
      hp_cnt <= hp_cnt + ONE;
    end
  end

endmodule

// File: rtl/tone_generator.sv
// Note/octave to buzzer square wave with a fixed silent gap between notes.
// Latency: 1-cycle input register; free-running output, no backpressure.
module tone_generator
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned GAP_CYCLES = 2_000_000,
  parameter int          HP_W       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] note_in,
  input  logic [1:0] octave,
  input  logic       retrig,
  output logic       speaker,
  output logic       note_active,
  output logic [2:0] cur_note
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t          state, state_nxt;
  logic [2:0]      note_q, lat_note;
  logic [1:0]      oct_q, lat_oct;
  logic [HP_W-1:0] hp_sel;
  logic [GAP_W-1:0] gap_cnt;
  logic            start, changed, run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_q <= REST;
      oct_q  <= 2'd0;
    end else begin
      note_q <= note_in;
      oct_q  <= octave;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    changed   = (note_q == REST) || (note_q != lat_note) || (oct_q != lat_oct) || retrig;
    case (state)
      IDLE: if (enable && note_q != REST) begin
        state_nxt = TONE;
        start     = 1'b1;
      end
      TONE: begin
        if (!enable)     state_nxt = IDLE;
        else if (changed) state_nxt = GAP;
      end
      GAP: begin
        if (!enable || gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lat_note <= REST;
      lat_oct  <= 2'd0;
      hp_sel   <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        lat_note <= note_q;
        lat_oct  <= oct_q;
        hp_sel   <= HP_W'(hp_of(note_q, oct_q, CLK_HZ));
      end
      if (state == GAP && state_nxt == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else                                  gap_cnt <= '0;
    end
  end

  // Divider stops on the same edge that leaves TONE, so speaker is low in that cycle.
  assign run = (state == TONE) && (state_nxt == TONE);

  square_divider #(.HP_W(HP_W)) u_div (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .half_period (hp_sel),
    .out         (speaker)
  );

  assign note_active = (state == TONE);
  assign cur_note    = note_active ? lat_note : REST;

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator at CLK_HZ=1 MHz, GAP_CYCLES=50.
module tb_tone_generator;

  logic       clk = 1'b0;
  logic       rst, enable, retrig;
  logic [2:0] note_in;
  logic [1:0] octave;
  logic       speaker, note_active;
  logic [2:0] cur_note;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] note;
    logic [1:0] oct;
    int         hp;
    logic [2:0] cur;
  } vec_t;

  typedef struct {
    int         hp;
    logic [2:0] cur;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  tone_generator #(.CLK_HZ(1_000_000), .GAP_CYCLES(50), .HP_W(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .note_in     (note_in),
    .octave      (octave),
    .retrig      (retrig),
    .speaker     (speaker),
    .note_active (note_active),
    .cur_note    (cur_note)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until speaker changes, -1 on timeout.
  task automatic wait_toggle(output int n);
    logic prev;
    bit   done;
    prev = speaker;
    done = 1'b0;
    n    = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (speaker != prev) done = 1'b1;
      else if (n >= 6000) begin
        n    = -1;
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_active(output int n);
    n = 0;
    while (!note_active && n >= 0) begin
      @(negedge clk);
      n++;
      if (n >= 200) n = -1;
    end
  endtask

  // Counts silent cycles between two tones; optional retrig / note change 10 cycles in.
  task automatic count_gap(input bit pulse_retrig, input logic [2:0] mid_note,
                           output int n, output int spk_hi);
    int t;
    bit started, done;
    t = 0; started = 1'b0; done = 1'b0; n = 0; spk_hi = 0;
    while (!done) begin
      @(negedge clk);
      t++;
      retrig = 1'b0;
      if (!note_active) begin
        started = 1'b1;
        n++;
        if (speaker) spk_hi++;
        if (n == 10 && pulse_retrig) retrig = 1'b1;
        if (n == 10 && mid_note != 3'd0) note_in = mid_note;
      end else if (started) done = 1'b1;
      if (t >= 500) begin
        n    = -1;
        done = 1'b1;
      end
    end
  endtask

  task automatic pop_check(input string name, input int hp_meas);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({name, "_cur"}, int'(cur_note), int'(e.cur));
      chk({name, "_hp"}, hp_meas, e.hp);
    end
  endtask

  task automatic wait_speaker_high();
    int n;
    wait_toggle(n);
    if (n >= 0 && !speaker) wait_toggle(n);
    chk("speaker_high_seen", int'(speaker), 1);
  endtask

  initial begin
    int n, n1, n2, hi;

    vecs[0] = '{3'd6, 2'd0, 2272, 3'd6};
    vecs[1] = '{3'd6, 2'd1, 1136, 3'd6};
    vecs[2] = '{3'd6, 2'd2,  568, 3'd6};
    vecs[3] = '{3'd6, 2'd3, 1136, 3'd6};
    vecs[4] = '{3'd1, 2'd1, 1908, 3'd1};
    vecs[5] = '{3'd4, 2'd1, 1432, 3'd4};
    vecs[6] = '{3'd5, 2'd0, 2550, 3'd5};
    vecs[7] = '{3'd7, 2'd2,  506, 3'd7};

    rst = 1'b1; enable = 1'b1; note_in = 3'd6; octave = 2'd1; retrig = 1'b0;

    // Reset held with a note present
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_speaker", int'(speaker), 0);
      chk("rst_active", int'(note_active), 0);
      chk("rst_cur", int'(cur_note), 0);
    end
    rst = 1'b0;
    wait_active(n);
    chk("rst_release_to_tone", int'(n > 0), 1);
    wait_toggle(n);
    chk("first_toggle_after_entry", n, 1136);

    // Table: note/octave -> half-period
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      enable  = 1'b0;
      note_in = vecs[i].note;
      octave  = vecs[i].oct;
      cyc(2);
      enable = 1'b1;
      sb.push_back('{vecs[i].hp, vecs[i].cur});
      wait_toggle(n1);
      wait_toggle(n2);
      chk($sformatf("vec%0d_first", i), n1, vecs[i].hp + 1);
      pop_check($sformatf("vec%0d", i), n2);
    end

    // Note change C -> E
    enable = 1'b0; note_in = 3'd1; octave = 2'd1;
    cyc(2);
    enable = 1'b1;
    wait_active(n);
    cyc(50);
    chk("c_cur", int'(cur_note), 1);
    note_in = 3'd3;
    sb.push_back('{1515, 3'd3});
    count_gap(1'b0, 3'd0, n, hi);
    chk("chg_gap_len", n, 51);
    chk("chg_gap_speaker", hi, 0);
    wait_toggle(n2);
    pop_check("chg", n2);

    // Retrig on held D, second retrig inside gap ignored
    enable = 1'b0; note_in = 3'd2;
    cyc(2);
    enable = 1'b1;
    wait_active(n);
    cyc(30);
    retrig = 1'b1;
    sb.push_back('{1700, 3'd2});
    count_gap(1'b1, 3'd0, n, hi);
    chk("retrig_gap_len", n, 51);
    chk("retrig_gap_speaker", hi, 0);
    wait_toggle(n2);
    pop_check("retrig", n2);

    // Simultaneous retrig and note change: one gap, new note G
    retrig = 1'b1; note_in = 3'd5;
    sb.push_back('{1275, 3'd5});
    count_gap(1'b0, 3'd0, n, hi);
    chk("both_gap_len", n, 51);
    wait_toggle(n2);
    pop_check("both", n2);

    // Note change during gap does not restart it; latest note wins
    note_in = 3'd4;
    sb.push_back('{1012, 3'd7});
    count_gap(1'b0, 3'd7, n, hi);
    chk("midgap_gap_len", n, 51);
    wait_toggle(n2);
    pop_check("midgap", n2);

    // enable=0 mid-tone: silent next cycle, no gap on re-enable
    wait_speaker_high();
    enable = 1'b0;
    @(negedge clk);
    chk("dis_speaker", int'(speaker), 0);
    chk("dis_active", int'(note_active), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_active", int'(note_active), 1);
    chk("reen_cur", int'(cur_note), 7);

    // Rest held: silent indefinitely, retrig in IDLE ignored
    note_in = 3'd0;
    cyc(2);
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      retrig = (i == 150);
      if (speaker || note_active || cur_note != 3'd0) hi++;
    end
    retrig = 1'b0;
    chk("rest_silent", hi, 0);

    // Async reset mid-tone
    note_in = 3'd6; octave = 2'd2;
    wait_active(n);
    wait_speaker_high();
    #2 rst = 1'b1;
    #1;
    chk("arst_speaker", int'(speaker), 0);
    chk("arst_active", int'(note_active), 0);
    chk("arst_cur", int'(cur_note), 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
